// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operation select encoding on the mode input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit combinational full adder used as the serial datapath core.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry of the three input bits
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one result bit per clock, LSB first.
// Subtraction is a + ~b + 1, so cout doubles as the no-borrow flag.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_a_q, shift_a_d;
    logic [WIDTH-1:0]  shift_b_q, shift_b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]     count_q, count_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              accept;
    logic              fa_s, fa_co;

    full_adder_1b u_fa (
        .a  (shift_a_q[0]),
        .b  (shift_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state: load on accept, step one bit per cycle in BUSY, hold otherwise
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        count_d   = count_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        accept    = start && (state_q != BUSY);

        if (accept) begin
            state_d   = BUSY;
            shift_a_d = a;
            shift_b_d = (mode == MODE_SUB) ? ~b : b;
            carry_d   = (mode == MODE_SUB) ? 1'b1 : cin;
            count_d   = '0;
            sum_d     = '0;
            cout_d    = 1'b0;
            ovf_d     = 1'b0;
            valid_d   = 1'b0;
        end else if (state_q == BUSY) begin
            sum_d     = {fa_s, sum_q[WIDTH-1:1]};
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            carry_d   = fa_co;
            if (count_q == LAST) begin
                // carry_q is the carry into the MSB on this last step
                state_d = DONE;
                cout_d  = fa_co;
                ovf_d   = carry_q ^ fa_co;
                valid_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // State registers, cleared asynchronously so an aborted operation leaves no trace
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign ready = (state_q != BUSY);
    assign busy  = (state_q == BUSY);
    assign valid = valid_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH 4, 8 and 16 with a result scoreboard.
module tb_serial_addsub;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        start4 = 1'b0, start8 = 1'b0, start16 = 1'b0;

    logic        rdy4, bsy4, vld4, co4, ov4;
    logic        rdy8, bsy8, vld8, co8, ov8;
    logic        rdy16, bsy16, vld16, co16, ov16;
    logic [3:0]  sum4;
    logic [7:0]  sum8;
    logic [15:0] sum16;

    exp_t sb[$];
    exp_t last_e;
    int   ntot = 0;
    int   npass = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .cin(cin),
        .a(a[3:0]), .b(b[3:0]), .ready(rdy4), .busy(bsy4), .valid(vld4),
        .sum(sum4), .cout(co4), .ovf(ov4));

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .cin(cin),
        .a(a[7:0]), .b(b[7:0]), .ready(rdy8), .busy(bsy8), .valid(vld8),
        .sum(sum8), .cout(co8), .ovf(ov8));

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .cin(cin),
        .a(a), .b(b), .ready(rdy16), .busy(bsy16), .valid(vld16),
        .sum(sum16), .cout(co16), .ovf(ov16));

    // Behavioural reference: full-width add with signed overflow from operand signs
    function automatic exp_t model(input int w, input logic [15:0] ia, ib,
                                   input logic im, ic);
        logic [16:0] m, x, y, f;
        exp_t e;
        m    = (17'd1 << w) - 17'd1;
        x    = {1'b0, ia} & m;
        y    = {1'b0, (im ? ~ib : ib)} & m;
        f    = x + y + {16'd0, (im ? 1'b1 : ic)};
        e.s  = f[15:0] & m[15:0];
        e.co = f[w];
        e.ov = (x[w-1] == y[w-1]) && (f[w-1] != x[w-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            4:       start4  = v;
            8:       start8  = v;
            default: start16 = v;
        endcase
    endtask

    task automatic get(input int w, output logic v, output logic r, output logic bs,
                       output logic [15:0] s, output logic co, output logic ov);
        case (w)
            4:       begin v = vld4;  r = rdy4;  bs = bsy4;  s = {12'd0, sum4}; co = co4;  ov = ov4;  end
            8:       begin v = vld8;  r = rdy8;  bs = bsy8;  s = {8'd0, sum8};  co = co8;  ov = ov8;  end
            default: begin v = vld16; r = rdy16; bs = bsy16; s = sum16;         co = co16; ov = ov16; end
        endcase
    endtask

    // Called just after an accepting edge: wait for valid, then score the result
    task automatic wait_result(input int w, input bit chk_lat);
        logic v, r, bs, co, ov;
        logic [15:0] s;
        int lat;
        exp_t e;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            get(w, v, r, bs, s, co, ov);
        end while (!v && lat < 64);
        chk($sformatf("valid_w%0d", w), 32'(v), 32'd1);
        if (chk_lat) chk($sformatf("latency_w%0d", w), 32'(lat), 32'(w));
        e = sb.pop_front();
        last_e = e;
        chk($sformatf("sum_w%0d", w), 32'(s), 32'(e.s));
        chk($sformatf("cout_w%0d", w), 32'(co), 32'(e.co));
        chk($sformatf("ovf_w%0d", w), 32'(ov), 32'(e.ov));
    endtask

    // One complete operation; operands are scrambled after acceptance
    task automatic do_op(input int w, input logic [15:0] ia, ib, input logic im, ic,
                         input bit chk_lat);
        @(negedge clk);
        a = ia; b = ib; mode = im; cin = ic;
        set_start(w, 1'b1);
        sb.push_back(model(w, ia, ib, im, ic));
        @(posedge clk); #1;
        set_start(w, 1'b0);
        a = 16'($urandom); b = 16'($urandom); mode = ~im; cin = ~ic;
        wait_result(w, chk_lat);
    endtask

    initial begin
        logic v, r, bs, co, ov;
        logic [15:0] s;

        // Reset state
        #12;
        get(8, v, r, bs, s, co, ov);
        chk("rst_ready", 32'(r), 32'd1);
        chk("rst_busy", 32'(bs), 32'd0);
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_sum", 32'(s), 32'd0);
        chk("rst_cout_ovf", {30'd0, co, ov}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed 4-bit cases
        do_op(4, 16'h5, 16'h3, 1'b0, 1'b0, 1'b1);
        do_op(4, 16'hF, 16'h1, 1'b0, 1'b0, 1'b1);
        do_op(4, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);

        // DONE holds its result
        repeat (3) @(posedge clk);
        #1;
        get(4, v, r, bs, s, co, ov);
        chk("hold_valid", 32'(v), 32'd1);
        chk("hold_ready", 32'(r), 32'd1);
        chk("hold_sum", 32'(s), 32'(last_e.s));

        // Directed 8-bit subtracts
        do_op(8, 16'h05, 16'h07, 1'b1, 1'b0, 1'b1);
        do_op(8, 16'h80, 16'h01, 1'b1, 1'b0, 1'b1);

        // Start held through BUSY with new operands, then accepted in DONE
        @(negedge clk);
        a = 16'h12; b = 16'h34; mode = 1'b0; cin = 1'b1;
        start8 = 1'b1;
        sb.push_back(model(8, 16'h12, 16'h34, 1'b0, 1'b1));
        @(posedge clk); #1;
        a = 16'hF0; b = 16'h0F; mode = 1'b1; cin = 1'b0;
        sb.push_back(model(8, 16'hF0, 16'h0F, 1'b1, 1'b0));
        wait_result(8, 1'b1);
        @(posedge clk); #1;
        start8 = 1'b0;
        get(8, v, r, bs, s, co, ov);
        chk("b2b_valid_drop", 32'(v), 32'd0);
        chk("b2b_no_idle", 32'(bs), 32'd1);
        wait_result(8, 1'b1);

        // Reset mid-BUSY aborts and clears asynchronously
        @(negedge clk);
        a = 16'h55; b = 16'h0F; mode = 1'b0; cin = 1'b0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        get(8, v, r, bs, s, co, ov);
        chk("abort_sum", 32'(s), 32'd0);
        chk("abort_valid", 32'(v), 32'd0);
        chk("abort_busy", 32'(bs), 32'd0);
        chk("abort_ready", 32'(r), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(8, 16'h10, 16'h20, 1'b0, 1'b0, 1'b1);

        // Random sets against the reference for each width
        foreach (sb[i]) chk("sb_leftover", 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            int w;
            w = (k == 0) ? 4 : (k == 1) ? 8 : 16;
            for (int n = 0; n < 1000; n++)
                do_op(w, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), (n < 5));
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
